glb_read_dma: RTL and testbench

GLB_READ_DMA -- requirements
Module: glb_read_dma

---
 rtl/glb_read_dma.sv | 142 ++++++++++++++
 tb/tb_glb_read_dma.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/glb_read_dma.sv
// Streams a byte range from the GLB into a small output FIFO, then presents it as 32-bit words on a valid/ready port.
// Optional m_last output when GLB_READ_LAST_EN is defined.
module glb_read_dma #(
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  byte_len,
    output logic                  busy,
    output logic                  done,
    output logic [3:0]            glb_re,
    output logic [ADDR_WIDTH-1:0] glb_raddr,
    input  logic [31:0]           glb_dout,
    output logic                  m_valid,
    input  logic                  m_ready,
`ifdef GLB_READ_LAST_EN
    output logic                  m_last,
`endif
    output logic [31:0]           m_data
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]  rem_q;
    logic                  inflight_q;
    logic [31:0]           mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_nxt;
    logic                  issue;
    logic                  last_read;
    logic                  push;
    logic                  pop;
    logic [LEN_WIDTH-1:0]  step;

    // Reads in flight reserve a FIFO slot so a returning word always has room.
    assign issue     = (state == S_READ) && ((count + CW'(inflight_q)) < CW'(FIFO_DEPTH));
    assign last_read = rem_q <= LEN_WIDTH'(4);
    assign step      = last_read ? rem_q : LEN_WIDTH'(4);
    assign push      = inflight_q;
    assign pop       = m_valid && m_ready;
    assign count_nxt = count + CW'(push) - CW'(pop);

    always_comb begin
        glb_re = 4'b0000;
        if (issue) begin
            if (!last_read || rem_q == LEN_WIDTH'(4)) begin
                glb_re = 4'b1111;
            end else begin
                case (rem_q[1:0])
                    2'd3:    glb_re = 4'b0111;
                    2'd2:    glb_re = 4'b0011;
                    default: glb_re = 4'b0001;
                endcase
            end
        end
    end

    assign glb_raddr = addr_q;
    assign busy      = (state == S_READ) || (state == S_DRAIN);
    assign done      = (state == S_DONE);
    assign m_valid   = (count != '0);
    assign m_data    = m_valid ? mem[rd_ptr] : 32'h0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= issue;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        addr_q <= base_addr;
                        rem_q  <= byte_len;
                        state  <= (byte_len == '0) ? S_DONE : S_READ;
                    end
                end
                S_READ: begin
                    if (issue) begin
                        addr_q <= addr_q + ADDR_WIDTH'(4);
                        rem_q  <= rem_q - step;
                        if (last_read) state <= S_DRAIN;
                    end
                end
                // Finish as soon as the final word leaves, so done follows the last pop by one cycle.
                S_DRAIN: begin
                    if (count_nxt == '0 && !inflight_q) state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= glb_dout;
    end

`ifdef GLB_READ_LAST_EN
    logic inflight_last_q;
    logic last_mem [FIFO_DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) inflight_last_q <= 1'b0;
        else     inflight_last_q <= issue && last_read;
    end

    always_ff @(posedge clk) begin
        if (push) last_mem[wr_ptr] <= inflight_last_q;
    end

    assign m_last = m_valid && last_mem[rd_ptr];
`endif

endmodule

// File: tb/tb_glb_read_dma.sv
// Directed bench for glb_read_dma with a behavioural GLB that returns {a+3,a+2,a+1,a} with disabled bytes as 0x00.
module tb_glb_read_dma;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] byte_len;
    logic        busy;
    logic        done;
    logic [3:0]  glb_re;
    logic [31:0] glb_raddr;
    logic [31:0] glb_dout;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
`ifdef GLB_READ_LAST_EN
    logic        m_last;
`endif

    int chk = 0;
    int err = 0;
    int cyc = 0;
    int start_cyc = 0;
    int stall_bad = 0;
    logic [31:0] stall_exp;
    logic [3:0]  rd_re [$];
    logic [31:0] rd_addr [$];
    int          rd_cyc [$];
    logic [31:0] out_dat [$];
    int          out_cyc [$];
    int          done_cyc [$];

    glb_read_dma #(.ADDR_WIDTH(32), .LEN_WIDTH(16), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .byte_len(byte_len),
        .busy(busy), .done(done), .glb_re(glb_re), .glb_raddr(glb_raddr), .glb_dout(glb_dout),
        .m_valid(m_valid), .m_ready(m_ready),
`ifdef GLB_READ_LAST_EN
        .m_last(m_last),
`endif
        .m_data(m_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        if (glb_re != 4'b0000)
            glb_dout <= {glb_re[3] ? glb_raddr[7:0] + 8'd3 : 8'h00,
                         glb_re[2] ? glb_raddr[7:0] + 8'd2 : 8'h00,
                         glb_re[1] ? glb_raddr[7:0] + 8'd1 : 8'h00,
                         glb_re[0] ? glb_raddr[7:0]        : 8'h00};
        else
            glb_dout <= 32'hDEADBEEF;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (glb_re != 4'b0000) begin
                rd_re.push_back(glb_re); rd_addr.push_back(glb_raddr); rd_cyc.push_back(cyc);
            end
            if (m_valid && m_ready) begin
                out_dat.push_back(m_data); out_cyc.push_back(cyc);
            end
            if (m_valid && !m_ready && m_data !== stall_exp) stall_bad++;
            if (done) done_cyc.push_back(cyc);
            if (start) start_cyc = cyc;
        end
    end

    task automatic clear_logs();
        rd_re.delete(); rd_addr.delete(); rd_cyc.delete();
        out_dat.delete(); out_cyc.delete(); done_cyc.delete();
        stall_bad = 0;
    endtask

    task automatic pulse_start(input logic [31:0] b, input logic [15:0] l);
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; byte_len = l;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done) begin seen = 1'b1; break; end
        end
        chk++;
        if (!seen) begin err++; $display("FAIL %s_timeout: done not seen in 300 cycles", name); end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; base_addr = '0; byte_len = '0; m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk++;
        if ({busy, done, glb_re, glb_raddr, m_valid, m_data} !== 70'h0) begin
            err++; $display("FAIL reset_state: busy=%b done=%b re=%b addr=%h valid=%b data=%h, want all 0",
                            busy, done, glb_re, glb_raddr, m_valid, m_data);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [31:0] exp [4] = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
        clear_logs(); m_ready = 1'b1;
        pulse_start(32'h100, 16'd16);
        wait_done("basic");
        chk++;
        if (rd_re.size() != 4 || out_dat.size() != 4) begin
            err++; $display("FAIL basic_counts: reads=%0d words=%0d, want 4 and 4", rd_re.size(), out_dat.size());
        end
        for (int i = 0; i < 4 && i < rd_re.size(); i++) begin
            chk++;
            if (rd_re[i] !== 4'hF || rd_addr[i] !== 32'h100 + 32'(4*i) || rd_cyc[i] != start_cyc + 1 + i) begin
                err++; $display("FAIL basic_rd%0d: re=%b addr=%h cyc=%0d, want 1111 %h %0d",
                                i, rd_re[i], rd_addr[i], rd_cyc[i], 32'h100 + 32'(4*i), start_cyc + 1 + i);
            end
        end
        for (int i = 0; i < 4 && i < out_dat.size(); i++) begin
            chk++;
            if (out_dat[i] !== exp[i] || out_cyc[i] != start_cyc + 3 + i) begin
                err++; $display("FAIL basic_word%0d: data=%h cyc=%0d, want %h %0d",
                                i, out_dat[i], out_cyc[i], exp[i], start_cyc + 3 + i);
            end
        end
        chk++;
        if (done_cyc.size() != 1 || done_cyc[0] != start_cyc + 7) begin
            err++; $display("FAIL basic_done: pulses=%0d first=%0d, want 1 at %0d",
                            done_cyc.size(), done_cyc.size() ? done_cyc[0] : -1, start_cyc + 7);
        end
    endtask

    task automatic test_partial();
        clear_logs(); m_ready = 1'b1;
        pulse_start(32'h200, 16'd7);
        wait_done("partial");
        chk++;
        if (rd_re.size() != 2 || rd_re[0] !== 4'b1111 || rd_addr[0] !== 32'h200
            || rd_re[1] !== 4'b0111 || rd_addr[1] !== 32'h204) begin
            err++; $display("FAIL partial_reads: n=%0d re0=%b a0=%h re1=%b a1=%h, want 2 1111@200 0111@204",
                            rd_re.size(), rd_re[0], rd_addr[0], rd_re[1], rd_addr[1]);
        end
        chk++;
        if (out_dat.size() != 2 || out_dat[0] !== 32'h03020100 || out_dat[1] !== 32'h00060504) begin
            err++; $display("FAIL partial_words: n=%0d w0=%h w1=%h, want 2 03020100 00060504",
                            out_dat.size(), out_dat[0], out_dat[1]);
        end
    endtask

    task automatic test_backpressure(input logic [15:0] len, input string name);
        int nwords = (int'(len) + 3) / 4;
        clear_logs(); m_ready = 1'b0; stall_exp = 32'h03020100;
        pulse_start(32'h300, len);
        repeat (9) @(posedge clk);
        #1;
        chk++;
        if (rd_re.size() != 4 || glb_re !== 4'b0000) begin
            err++; $display("FAIL %s_stall_reads: reads=%0d re=%b, want 4 and 0000", name, rd_re.size(), glb_re);
        end
        chk++;
        if (stall_bad != 0 || !m_valid) begin
            err++; $display("FAIL %s_stall_hold: unstable=%0d valid=%b, want 0 and 1", name, stall_bad, m_valid);
        end
        m_ready = 1'b1;
        wait_done(name);
        chk++;
        if (out_dat.size() != nwords || rd_re.size() != nwords) begin
            err++; $display("FAIL %s_counts: words=%0d reads=%0d, want %0d", name, out_dat.size(), rd_re.size(), nwords);
        end
        for (int i = 0; i < nwords && i < out_dat.size(); i++) begin
            logic [7:0] b = 8'(4*i);
            chk++;
            if (out_dat[i] !== {b + 8'd3, b + 8'd2, b + 8'd1, b}) begin
                err++; $display("FAIL %s_word%0d: data=%h, want %h", name, i, out_dat[i], {b + 8'd3, b + 8'd2, b + 8'd1, b});
            end
        end
    endtask

    task automatic test_zero_len();
        clear_logs(); m_ready = 1'b1;
        pulse_start(32'h400, 16'd0);
        wait_done("zero");
        chk++;
        if (rd_re.size() != 0 || out_dat.size() != 0 || done_cyc.size() != 1 || done_cyc[0] != start_cyc + 1) begin
            err++; $display("FAIL zero_len: reads=%0d words=%0d pulses=%0d done_at=%0d, want 0 0 1 %0d",
                            rd_re.size(), out_dat.size(), done_cyc.size(),
                            done_cyc.size() ? done_cyc[0] : -1, start_cyc + 1);
        end
    endtask

    task automatic test_mid_reset();
        bit hit = 1'b0;
        clear_logs(); m_ready = 1'b1;
        pulse_start(32'h900, 16'd32);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rd_re.size() == 2) begin hit = 1'b1; break; end
        end
        chk++;
        if (!hit) begin err++; $display("FAIL midrst_reads: reads=%0d, want 2", rd_re.size()); end
        rst = 1'b1;
        #1;
        chk++;
        if ({busy, done, glb_re, glb_raddr, m_valid, m_data} !== 70'h0) begin
            err++; $display("FAIL midrst_outputs: busy=%b done=%b re=%b addr=%h valid=%b data=%h, want all 0",
                            busy, done, glb_re, glb_raddr, m_valid, m_data);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        clear_logs();
        pulse_start(32'h500, 16'd8);
        wait_done("midrst");
        chk++;
        if (rd_re.size() != 2 || rd_addr[0] !== 32'h500 || rd_addr[1] !== 32'h504 || out_dat.size() != 2
            || out_dat[0] !== 32'h03020100 || out_dat[1] !== 32'h07060504) begin
            err++; $display("FAIL midrst_rerun: reads=%0d a0=%h a1=%h words=%0d w0=%h w1=%h, want 2 500 504 2 03020100 07060504",
                            rd_re.size(), rd_addr[0], rd_addr[1], out_dat.size(), out_dat[0], out_dat[1]);
        end
    endtask

    task automatic test_start_while_busy();
        clear_logs(); m_ready = 1'b1;
        pulse_start(32'h600, 16'd12);
        start = 1'b1; base_addr = 32'h700; byte_len = 16'd4;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("busystart");
        repeat (5) @(posedge clk);
        chk++;
        if (rd_re.size() != 3 || rd_addr[0] !== 32'h600 || rd_addr[2] !== 32'h608 || out_dat.size() != 3
            || out_dat[2] !== 32'h0B0A0908 || done_cyc.size() != 1) begin
            err++; $display("FAIL busystart: reads=%0d a0=%h a2=%h words=%0d w2=%h pulses=%0d, want 3 600 608 3 0b0a0908 1",
                            rd_re.size(), rd_addr[0], rd_addr[2], out_dat.size(), out_dat[2], done_cyc.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_partial();
        test_backpressure(16'd16, "bp16");
        test_backpressure(16'd24, "bp24");
        test_zero_len();
        test_mid_reset();
        test_start_while_busy();
        $display("Simulation finished: %0d checks, %0d errors", chk, err);
        $finish;
    end
endmodule
